// File: rtl/morse_decoder_pkg.sv
// Shared types and default timing constants for the Morse key decoding chain.
package morse_decoder_pkg;

  localparam int MORSE_SYMBOL_MAX_C    = 6;
  localparam int MORSE_CNT_W_C         = 28;
  localparam int MORSE_DASH_TICKS_C    = 30_000_000;
  localparam int MORSE_ILLEGAL_TICKS_C = 100_000_000;
  localparam int MORSE_CHAR_TICKS_C    = 175_000_000;
  localparam int MORSE_WORD_TICKS_C    = 250_000_000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    WORD_WAIT
  } morse_framer_state_e;

endpackage

// File: rtl/morse_char_slot.sv
// One-entry valid/ready output register; a load into an unaccepted entry is
// dropped and flagged with a one-cycle overrun pulse.
module morse_char_slot #(
  parameter int MAX_SYMBOLS = 6,
  parameter int LEN_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   space_i,
  input  logic [MAX_SYMBOLS-1:0] code_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   err_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic                   space_o,
  output logic [MAX_SYMBOLS-1:0] code_o,
  output logic [LEN_W-1:0]       len_o,
  output logic                   err_o,
  output logic                   overrun_o
);

  logic                   valid_q, valid_d;
  logic                   space_q, space_d;
  logic [MAX_SYMBOLS-1:0] code_q, code_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   err_q, err_d;
  logic                   overrun_q, overrun_d;
  logic                   accept;

  // A beat leaving in the same cycle frees the entry for the incoming load.
  always_comb begin
    valid_d   = valid_q;
    space_d   = space_q;
    code_d    = code_q;
    len_d     = len_q;
    err_d     = err_q;
    overrun_d = 1'b0;
    accept    = valid_q & ready_i;
    if (accept) valid_d = 1'b0;
    if (load_i) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        space_d = space_i;
        code_d  = code_i;
        len_d   = len_i;
        err_d   = err_i;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      space_q   <= 1'b0;
      code_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      space_q   <= space_d;
      code_q    <= code_d;
      len_q     <= len_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign space_o   = space_q;
  assign code_o    = code_q;
  assign len_o     = len_q;
  assign err_o     = err_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/morse_symbol_framer.sv
// Times key presses and idle gaps, packs dot/dash symbols into characters and
// hands them out over valid/ready. Define MORSE_SPACE_BEAT_EN for word-space beats.
module morse_symbol_framer
  import morse_decoder_pkg::*;
#(
  parameter int MAX_SYMBOLS   = MORSE_SYMBOL_MAX_C,
  parameter int CNT_W         = MORSE_CNT_W_C,
  parameter int DASH_TICKS    = MORSE_DASH_TICKS_C,
  parameter int ILLEGAL_TICKS = MORSE_ILLEGAL_TICKS_C,
  parameter int CHAR_TICKS    = MORSE_CHAR_TICKS_C,
  parameter int WORD_TICKS    = MORSE_WORD_TICKS_C
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               key_i,
  output logic [MAX_SYMBOLS-1:0]             char_code_o,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]   char_len_o,
  output logic                               char_err_o,
  output logic                               char_space_o,
  output logic                               char_valid_o,
  input  logic                               char_ready_i,
  output logic                               word_o,
  output logic                               overrun_o,
  output logic                               busy_o
);

  localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);
  // Press length is timer+1 at release, so thresholds are compared one lower.
  localparam logic [CNT_W-1:0] DASH_M1_C = CNT_W'(DASH_TICKS - 1);
  localparam logic [CNT_W-1:0] ILL_M1_C  = CNT_W'(ILLEGAL_TICKS - 1);
  localparam logic [CNT_W-1:0] CHAR_C    = CNT_W'(CHAR_TICKS);
  localparam logic [CNT_W-1:0] WORD_C    = CNT_W'(WORD_TICKS);

  morse_framer_state_e    state_q, state_d;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic [MAX_SYMBOLS-1:0] acc_code_q, acc_code_d;
  logic [LEN_W-1:0]       acc_len_q, acc_len_d;
  logic                   acc_err_q, acc_err_d;
  logic                   word_q, word_d;

  logic                   load, load_space, load_err, is_dash, is_illegal;
  logic [MAX_SYMBOLS-1:0] load_code;
  logic [LEN_W-1:0]       load_len;

  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == WORD_C) ? timer_q : timer_q + CNT_W'(1);
    acc_code_d = acc_code_q;
    acc_len_d  = acc_len_q;
    acc_err_d  = acc_err_q;
    word_d     = 1'b0;
    load       = 1'b0;
    load_space = 1'b0;
    load_code  = '0;
    load_len   = '0;
    load_err   = 1'b0;
    is_illegal = (timer_q >= ILL_M1_C);
    is_dash    = (timer_q >= DASH_M1_C);
    case (state_q)
      IDLE: begin
        if (key_i) begin
          state_d = PRESS;
          timer_d = '0;
        end
      end
      PRESS: begin
        if (!key_i) begin
          state_d = GAP;
          timer_d = '0;
          if (is_illegal) begin
            acc_err_d = 1'b1;
          end else if (acc_len_q < LEN_W'(MAX_SYMBOLS)) begin
            for (int i = 0; i < MAX_SYMBOLS; i++) begin
              if (i == MAX_SYMBOLS - 1 - int'(acc_len_q)) acc_code_d[i] = is_dash;
            end
            acc_len_d = acc_len_q + LEN_W'(1);
          end else begin
            acc_err_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (key_i) begin
          state_d = PRESS;
          timer_d = '0;
        end else if (timer_q == CHAR_C) begin
          load       = (acc_len_q != '0) || acc_err_q;
          load_code  = acc_code_q;
          load_len   = acc_len_q;
          load_err   = acc_err_q;
          acc_code_d = '0;
          acc_len_d  = '0;
          acc_err_d  = 1'b0;
          state_d    = WORD_WAIT;
        end
      end
      WORD_WAIT: begin
        if (key_i) begin
          state_d = PRESS;
          timer_d = '0;
        end else if (timer_q == WORD_C) begin
          word_d  = 1'b1;
          state_d = IDLE;
`ifdef MORSE_SPACE_BEAT_EN
          load       = 1'b1;
          load_space = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      acc_code_q <= '0;
      acc_len_q  <= '0;
      acc_err_q  <= 1'b0;
      word_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      acc_code_q <= acc_code_d;
      acc_len_q  <= acc_len_d;
      acc_err_q  <= acc_err_d;
      word_q     <= word_d;
    end
  end

  // Without the space-beat build, load_space never rises, so char_space_o stays 0.
  morse_char_slot #(
    .MAX_SYMBOLS(MAX_SYMBOLS),
    .LEN_W      (LEN_W)
  ) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .space_i  (load_space),
    .code_i   (load_code),
    .len_i    (load_len),
    .err_i    (load_err),
    .ready_i  (char_ready_i),
    .valid_o  (char_valid_o),
    .space_o  (char_space_o),
    .code_o   (char_code_o),
    .len_o    (char_len_o),
    .err_o    (char_err_o),
    .overrun_o(overrun_o)
  );

  assign word_o = word_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_morse_symbol_framer.sv
// Self-checking bench for morse_symbol_framer using short tick parameters;
// honours MORSE_SPACE_BEAT_EN when the design is built with it.
module tb_morse_symbol_framer;

  localparam int MAX = 6;
  localparam int DASH = 4;
  localparam int ILL = 10;
  localparam int CHR = 16;
  localparam int WRD = 24;
`ifdef MORSE_SPACE_BEAT_EN
  localparam bit SPACE_EN = 1'b1;
`else
  localparam bit SPACE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       space;
    logic       err;
    logic [2:0] len;
    logic [5:0] code;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_i = 1'b0;
  logic       char_ready_i = 1'b1;
  logic [5:0] char_code_o;
  logic [2:0] char_len_o;
  logic       char_err_o, char_space_o, char_valid_o, word_o, overrun_o, busy_o;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    relCyc = 0;
  int    riseCyc = -1;
  int    wordCyc = -1;
  int    words = 0;
  int    overruns = 0;
  logic  validPrev = 1'b0;
  beat_t gotQ[$];
  beat_t expQ[$];
  int    pressQ[$];
  beat_t spaceBeat = '{space: 1'b1, err: 1'b0, len: 3'd0, code: 6'd0};

  morse_symbol_framer #(
    .MAX_SYMBOLS(MAX), .CNT_W(8), .DASH_TICKS(DASH),
    .ILLEGAL_TICKS(ILL), .CHAR_TICKS(CHR), .WORD_TICKS(WRD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_i(key_i),
    .char_code_o(char_code_o), .char_len_o(char_len_o), .char_err_o(char_err_o),
    .char_space_o(char_space_o), .char_valid_o(char_valid_o),
    .char_ready_i(char_ready_i), .word_o(word_o), .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects accepted beats and pulse events at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      validPrev = 1'b0;
    end else begin
      if (char_valid_o && !validPrev && riseCyc < 0) riseCyc = cyc;
      validPrev = char_valid_o;
      if (char_valid_o && char_ready_i)
        gotQ.push_back({char_space_o, char_err_o, char_len_o, char_code_o});
      if (word_o) begin
        words++;
        wordCyc = cyc;
      end
      if (overrun_o) overruns++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    key_i = 1'b1;
    repeat (n) step();
    key_i = 1'b0;
    relCyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    key_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_presses(input int gap);
    foreach (pressQ[i]) begin
      press(pressQ[i]);
      if (i != pressQ.size() - 1) idle(gap);
    end
  endtask

  // Reference: classify every press, then pack the legal symbols MSB first.
  function automatic beat_t model_char();
    int    syms[$];
    beat_t b;
    b = '0;
    foreach (pressQ[i]) begin
      if (pressQ[i] >= ILL) b.err = 1'b1;
      else syms.push_back(pressQ[i] >= DASH ? 1 : 0);
    end
    if (syms.size() > MAX) b.err = 1'b1;
    for (int i = 0; i < syms.size() && i < MAX; i++) b.code[MAX-1-i] = (syms[i] != 0);
    b.len = 3'(syms.size() > MAX ? MAX : syms.size());
    return b;
  endfunction

  task automatic begin_scenario();
    gotQ.delete();
    expQ.delete();
    riseCyc = -1;
    wordCyc = -1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({char_code_o, char_len_o, char_err_o, char_space_o, char_valid_o, word_o, overrun_o, busy_o} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {char_code_o, char_len_o, char_err_o, char_space_o, char_valid_o, word_o, overrun_o, busy_o});
    end
    rst_n = 1'b1;
    repeat (30) step();
    checks++;
    if ({char_valid_o, word_o, overrun_o, busy_o} !== 4'd0 || words != 0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got valid/word/ovr/busy=%b words=%0d expected 0000/0", {char_valid_o, word_o, overrun_o, busy_o}, words);
    end
  endtask

  task automatic test_char_a();
    begin_scenario();
    pressQ = '{2, 6};
    expQ.push_back(model_char());
    if (SPACE_EN) expQ.push_back(spaceBeat);
    send_presses(3);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL a_busy: got %b expected 1", busy_o);
    end
    idle(30);
    checks++;
    if (gotQ.size() != expQ.size() || gotQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL a_count: got %0d beats expected %0d", gotQ.size(), expQ.size());
    end else begin
      if (gotQ[0] !== expQ[0]) begin
        errors++;
        $display("[TB] FAIL a_beat: got %h expected %h", gotQ[0], expQ[0]);
      end
    end
    checks++;
    if (riseCyc - relCyc != CHR + 1) begin
      errors++;
      $display("[TB] FAIL a_latency: got %0d cycles expected %0d", riseCyc - relCyc, CHR + 1);
    end
  endtask

  task automatic test_single(input string name, input int gap);
    begin_scenario();
    expQ.push_back(model_char());
    if (SPACE_EN) expQ.push_back(spaceBeat);
    send_presses(gap);
    idle(30);
    checks++;
    if (gotQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d beats expected %0d", name, gotQ.size(), expQ.size());
    end else begin
      foreach (gotQ[i]) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          errors++;
          $display("[TB] FAIL %s_beat%0d: got %h expected %h", name, i, gotQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_word();
    int w0;
    w0 = words;
    pressQ = '{2};
    test_single("word", 2);
    checks++;
    if (words - w0 != 1 || wordCyc - relCyc != WRD + 1) begin
      errors++;
      $display("[TB] FAIL word_pulse: got %0d pulses at %0d expected 1 at %0d", words - w0, wordCyc - relCyc, WRD + 1);
    end
  endtask

  task automatic test_stall();
    beat_t b1;
    int    ov0;
    begin_scenario();
    ov0 = overruns;
    char_ready_i = 1'b0;
    pressQ = '{2};
    b1 = model_char();
    expQ.push_back(b1);
    if (SPACE_EN) expQ.push_back(spaceBeat);
    press(2);
    idle(20);
    key_i = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i == 6) key_i = 1'b0;
      step();
      checks++;
      if ({char_valid_o, char_space_o, char_err_o, char_len_o, char_code_o} !== {1'b1, b1}) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got %b_%h expected 1_%h", i, char_valid_o, {char_space_o, char_err_o, char_len_o, char_code_o}, b1);
      end
    end
    char_ready_i = 1'b1;
    idle(20);
    checks++;
    if (overruns - ov0 != 1) begin
      errors++;
      $display("[TB] FAIL stall_overrun: got %0d pulses expected 1", overruns - ov0);
    end
    checks++;
    if (gotQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL stall_count: got %0d beats expected %0d", gotQ.size(), expQ.size());
    end else begin
      foreach (gotQ[i]) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          errors++;
          $display("[TB] FAIL stall_beat%0d: got %h expected %h", i, gotQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int w0;
    begin_scenario();
    press(2);
    idle(3);
    key_i = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    key_i = 1'b0;
    #2;
    checks++;
    if ({char_code_o, char_len_o, char_err_o, char_space_o, char_valid_o, word_o, overrun_o, busy_o} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h expected 0", {char_code_o, char_len_o, char_err_o, char_space_o, char_valid_o, word_o, overrun_o, busy_o});
    end
    step();
    rst_n = 1'b1;
    w0 = words;
    idle(40);
    checks++;
    if (gotQ.size() != 0 || words != w0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got %0d beats %0d words busy=%b expected 0 0 0", gotQ.size(), words - w0, busy_o);
    end
  endtask

  task automatic test_random();
    int nchar, gap, tail, kind, w0, expWords;
    begin_scenario();
    w0 = words;
    expWords = 0;
    for (int c = 0; c < 10; c++) begin
      pressQ.delete();
      nchar = $urandom_range(1, 7);
      for (int p = 0; p < nchar; p++) begin
        kind = $urandom_range(0, 6);
        if (kind < 3) pressQ.push_back($urandom_range(1, DASH - 1));
        else if (kind < 6) pressQ.push_back($urandom_range(DASH, ILL - 1));
        else pressQ.push_back($urandom_range(ILL, ILL + 4));
      end
      gap = $urandom_range(1, 10);
      tail = (c == 9 || $urandom_range(0, 1) == 1) ? 30 : $urandom_range(CHR + 2, WRD + 1);
      expQ.push_back(model_char());
      if (tail > WRD + 1) begin
        expWords++;
        if (SPACE_EN) expQ.push_back(spaceBeat);
      end
      send_presses(gap);
      idle(tail);
    end
    checks++;
    if (gotQ.size() != expQ.size() || words - w0 != expWords) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d beats %0d words expected %0d beats %0d words", gotQ.size(), words - w0, expQ.size(), expWords);
    end else begin
      foreach (gotQ[i]) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          errors++;
          $display("[TB] FAIL rand_beat%0d: got %h expected %h", i, gotQ[i], expQ[i]);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] start, space beat build = %0d", SPACE_EN);
    test_reset();
    test_char_a();
    pressQ = '{12};
    test_single("illegal", 2);
    pressQ = '{3, 4, 9};
    test_single("threshold", 2);
    pressQ = '{10};
    test_single("illegal_edge", 2);
    pressQ = '{2, 2, 2, 2, 2, 2, 2};
    test_single("overflow", 2);
    test_word();
    test_stall();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
